mac_fifo_loader: RTL and testbench
==================================

Name: mac_fifo_loader

Overview:
- Upstream feeder for the MAC-FIFO array.
- On `start`, reads NUM_ROWS+1 64-bit words from on-chip memory over an Avalon-MM read master:
  - words 0..NUM_ROWS-1 are matrix A rows;
  - word NUM_ROWS is vector B.
- Unpacks each word into 8 bytes and pushes them, one per cycle with full-backpressure, into the matching input FIFO.
- The top-level controller waits on `done` before starting MAC evaluation.

Parameters:
- NUM_ROWS, 8, number of A-row FIFOs; FIFO index NUM_ROWS is the B FIFO.
- BASE_ADDR, 0, word address of row 0.
- ADDR_W, 32, Avalon address width.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  level; rising edge sampled in IDLE begins a load
- busy  out  1  high from load accept until DONE
- done  out  1  high in DONE state
- error  out  1  timeout flag (optional feature)
- avm_address  out  ADDR_W  word address
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  64  read data
- avm_readdatavalid  in  1  readdata qualifier
- fifo_wr_en  out  NUM_ROWS+1  one-hot write strobe per FIFO
- fifo_wdata  out  8  byte to write
- fifo_full  in  NUM_ROWS+1  per-FIFO full flag

Behaviour:
- Reset is asynchronous, active-high. While `rst` is asserted every output is 0, the state is IDLE and the row counter is 0.
- Reset mid-operation abandons the load; no further FIFO writes occur.
- A response arriving after reset is ignored because `avm_read` was dropped.
- States: IDLE, REQ, WAIT, UNPACK, NEXT, DONE.
- IDLE:
  - outputs low;
  - `start` rising edge (start=1, previous start=0) → REQ, row=0, busy=1.
- REQ:
  - avm_read=1, avm_address=BASE_ADDR+row;
  - hold both stable while avm_waitrequest=1;
  - when waitrequest=0 at the clock edge → WAIT.
- WAIT:
  - avm_read=0;
  - on avm_readdatavalid=1, capture readdata into the unpacker, byte index=0 → UNPACK.
  - readdatavalid asserted in the same cycle as the REQ accept is ignored; minimum read latency is 1.
- UNPACK:
  - emits byte[idx] (idx 0 = bits [7:0], LSB first) to FIFO `row`;
  - fifo_wr_en[row]=1 only when fifo_full[row]=0;
  - when full, the strobe is 0 and idx holds (stall, no loss, no duplicate);
  - after idx 7 is written → NEXT.
- NEXT:
  - if row==NUM_ROWS → DONE;
  - otherwise row++ → REQ.
  - Adds one bubble cycle per word.
- DONE:
  - done=1, busy=0;
  - stays until start=0, then → IDLE;
  - a new load therefore requires a fresh rising edge.
- Strobe rules:
  - at most one fifo_wr_en bit is high in any cycle;
  - fifo_wdata is don't-care when no strobe is high but is driven 0 by rule.
- `start` toggling while busy is ignored.
- Best-case latency, start edge to done: (NUM_ROWS+1)×(1 REQ + 1 WAIT + 8 UNPACK + 1 NEXT) + 1 = 100 cycles at the defaults with zero waitstates and latency 1.
- Row counter width is $clog2(NUM_ROWS+1). The address add is ADDR_W-bit and wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: MAC_FIFO_LOADER_TIMEOUT_EN.
- Defined:
  - a counter runs in REQ and WAIT and clears on state exit;
  - reaching TIMEOUT_CYC → error=1, avm_read=0, go to DONE;
  - error clears on leaving DONE or on rst.
- Undefined: `error` is tied 0 and no counter exists.

Decomposition:
- Shared package `mac_fifo_pkg`:
  - the loader state enum (IDLE=0..DONE=5), so the top FSM can compare states symbolically;
  - localparams BYTES_PER_WORD=8 and BYTE_W=8.
- Sub-module `word_unpacker`:
  - 64-bit load register plus 3-bit index;
  - load, advance, byte_out, and last flags.

Test Plan:
1. Zero-wait memory, NUM_ROWS=8, word r = 64'h0807060504030201 + r×64'h0101010101010101 → FIFO r receives 01+r..08+r in order, B FIFO receives 09..10 hex, done asserts at cycle 100 after the start edge.
2. avm_waitrequest held high 5 cycles on row 3 → avm_address=BASE_ADDR+3 and avm_read stable all 5 cycles; data identical to test 1; done is delayed by 5 cycles.
3. fifo_full[2] high for 4 cycles while idx=3 of row 2 → no strobe in those cycles, byte 04+2 written once after release; no other FIFO is strobed.
4. rst pulsed during UNPACK of row 5 → all outputs 0 asynchronously; after release, IDLE with no writes; a new start edge reloads from row 0.
5. start held high through DONE and then re-asserted while busy → exactly one load occurs; the next load begins only after start=0 then 1.
6. MAC_FIFO_LOADER_TIMEOUT_EN defined, readdatavalid never returned on row 0 → error=1 and done=1 after 255 cycles, no FIFO writes.

Source files
------------

// File: rtl/mac_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_fifo_pkg
// Description : Shared types and constants for the MAC-FIFO loader.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_fifo_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    UNPACK = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } loader_state_e;

endpackage : mac_fifo_pkg
`default_nettype wire

// File: rtl/mac_fifo_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_fifo_loader_if
// Description : Avalon-MM read master bus plus the FIFO write bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_fifo_loader_if
  import mac_fifo_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int NUM_ROWS = 8
);

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic                avm_waitrequest;
  logic [WORD_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;
  logic [NUM_ROWS:0]   fifo_wr_en;
  logic [BYTE_W-1:0]   fifo_wdata;
  logic [NUM_ROWS:0]   fifo_full;

  modport master (
    output avm_address, avm_read, fifo_wr_en, fifo_wdata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, fifo_full
  );

  modport slave (
    input  avm_address, avm_read, fifo_wr_en, fifo_wdata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, fifo_full
  );

endinterface : mac_fifo_loader_if
`default_nettype wire

// File: rtl/mac_fifo_loader_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : word_unpacker
// Description : Holds one memory word and presents it a byte at a time, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module word_unpacker
  import mac_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              last_o
);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = '0;
    end else if (advance_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      idx_q <= idx_d;
      if (load_i) begin
        word_q <= word_i;
      end
    end
  end

  assign byte_o = word_q[{idx_q, 3'b000} +: BYTE_W];
  assign last_o = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule : word_unpacker
`default_nettype wire

// File: rtl/mac_fifo_loader.sv
`default_nettype none
// ============================================================================
// Module      : mac_fifo_loader
// Description : Reads NUM_ROWS+1 words over Avalon-MM and streams their bytes
//               into the per-row input FIFOs. Optional read watchdog enabled
//               by defining MAC_FIFO_LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_fifo_loader
  import mac_fifo_pkg::*;
#(
  parameter int NUM_ROWS    = 8,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  mac_fifo_loader_if.master bus
);

  localparam int NF = NUM_ROWS + 1;
  localparam int RW = $clog2(NUM_ROWS + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_REQ    = REQ;
  localparam logic [2:0] S_WAIT   = WAIT;
  localparam logic [2:0] S_UNPACK = UNPACK;
  localparam logic [2:0] S_NEXT   = NEXT;
  localparam logic [2:0] S_DONE   = DONE;

  logic [2:0]        state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic              start_q;
  logic              w_load, w_adv, w_wr, w_last, w_tmo_hit;
  logic [BYTE_W-1:0] w_byte;

  word_unpacker u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_load),
    .advance_i (w_adv),
    .word_i    (bus.avm_readdata),
    .byte_o    (w_byte),
    .last_o    (w_last)
  );

  // A full FIFO simply withholds the strobe; the unpacker index does not move.
  assign w_wr = (state_q == S_UNPACK) && !bus.fifo_full[row_q];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    w_load  = 1'b0;
    w_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          state_d = S_REQ;
          row_d   = '0;
        end
      end
      S_REQ: begin
        if (!bus.avm_waitrequest) begin
          state_d = S_WAIT;
        end else if (w_tmo_hit) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (bus.avm_readdatavalid) begin
          state_d = S_UNPACK;
          w_load  = 1'b1;
        end else if (w_tmo_hit) begin
          state_d = S_DONE;
        end
      end
      S_UNPACK: begin
        if (w_wr) begin
          w_adv = 1'b1;
          if (w_last) begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (row_q == ROW_LAST) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      start_q <= start;
    end
  end

`ifdef MAC_FIFO_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          w_in_rd;

  assign w_in_rd   = (state_q == S_REQ) || (state_q == S_WAIT);
  assign w_tmo_hit = w_in_rd && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (w_in_rd && (state_d == state_q)) begin
      tmo_d = tmo_q + 1'b1;
    end
    err_d = err_q;
    if (w_in_rd && (state_d == S_DONE)) begin
      err_d = 1'b1;
    end else if ((state_q == S_DONE) && (state_d != S_DONE)) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  logic w_unused_tmo_cfg;

  assign w_unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign w_tmo_hit        = 1'b0;
  assign error            = 1'b0;
`endif

  assign busy            = (state_q == S_REQ) || (state_q == S_WAIT) ||
                           (state_q == S_UNPACK) || (state_q == S_NEXT);
  assign done            = (state_q == S_DONE);
  assign bus.avm_read    = (state_q == S_REQ);
  assign bus.avm_address = bus.avm_read ? (ADDR_W'(BASE_ADDR) + ADDR_W'(row_q)) : '0;
  assign bus.fifo_wr_en  = w_wr ? (NF'(1) << row_q) : '0;
  assign bus.fifo_wdata  = w_wr ? w_byte : '0;

endmodule : mac_fifo_loader
`default_nettype wire

// File: tb/tb_mac_fifo_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_fifo_loader
// Description : Self-checking bench with a memory/FIFO model and a byte-stream
//               reference built from the memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_fifo_loader;

  localparam int NR   = 8;
  localparam int NF   = NR + 1;
  localparam int BASE = 16;
  localparam int AW   = 32;

  typedef struct {
    int lat;
    int stall_row;
    int stall_len;
    int full_fifo;
    int full_idx;
    int full_len;
    int exp_cyc;
  } vec_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy, done, error;

  logic          r_wait  = 1'b0;
  logic          r_rdv   = 1'b0;
  logic [63:0]   r_rdata = '0;
  logic [NR:0]   r_full  = '0;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem [NF];
  logic [7:0]  q_fifo [NF][$];
  logic [63:0] pend_d [$];
  int          pend_t [$];
  int          cyc = 0, n_wr = 0, n_acc = 0, first_addr = -1;
  int          lat = 1, stall_row = 0, stall_len = 0, stall_cnt = 0;
  int          full_fifo = 0, full_idx = 1, full_len = 0, full_cnt = 0;
  bit          rnd_mode = 1'b0, rdv_en = 1'b1, stalled = 1'b0;
  logic [AW-1:0] stall_addr = '0;
  vec_t        tbl [5];

  mac_fifo_loader_if #(.ADDR_W(AW), .NUM_ROWS(NR)) bus ();

  assign bus.avm_waitrequest   = r_wait;
  assign bus.avm_readdatavalid = r_rdv;
  assign bus.avm_readdata      = r_rdata;
  assign bus.fifo_full         = r_full;

  mac_fifo_loader #(
    .NUM_ROWS    (NR),
    .BASE_ADDR   (BASE),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .error (error),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Memory slave, FIFO sink and stream scoreboard
  always @(posedge clk) begin
    int idx;
    cyc++;
    stalled = 1'b0;
    if (!rst) begin
      if (bus.fifo_wr_en != '0) begin
        chk("strobe_onehot", 64'($countones(bus.fifo_wr_en)), 64'd1);
        chk("strobe_while_full", 64'(bus.fifo_wr_en & bus.fifo_full), 64'd0);
        for (int f = 0; f < NF; f++)
          if (bus.fifo_wr_en[f]) q_fifo[f].push_back(bus.fifo_wdata);
        n_wr++;
      end else if (bus.fifo_wdata != '0) begin
        chk("wdata_idle_zero", 64'(bus.fifo_wdata), 64'd0);
      end
      if (bus.avm_read && !bus.avm_waitrequest) begin
        n_acc++;
        if (first_addr < 0) first_addr = int'(bus.avm_address);
        if (rdv_en) begin
          idx = int'(bus.avm_address) - BASE;
          pend_d.push_back((idx >= 0 && idx < NF) ? mem[idx] : '1);
          pend_t.push_back(cyc + lat - 1);
        end
      end
      stalled    = bus.avm_read && bus.avm_waitrequest;
      stall_addr = bus.avm_address;
    end
    #1;
    r_rdv   = 1'b0;
    r_rdata = '0;
    if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
      r_rdv   = 1'b1;
      r_rdata = pend_d.pop_front();
      void'(pend_t.pop_front());
    end
    if (stalled && !rst) begin
      chk("stall_read_held", 64'(bus.avm_read), 64'd1);
      chk("stall_addr_held", 64'(bus.avm_address), 64'(stall_addr));
    end
    r_wait = 1'b0;
    if (bus.avm_read) begin
      if (rnd_mode) r_wait = ($urandom_range(0, 2) == 0);
      else if (stall_cnt < stall_len && bus.avm_address == AW'(BASE + stall_row)) begin
        r_wait = 1'b1;
        stall_cnt++;
      end
    end
    r_full = '0;
    if (rnd_mode) r_full = NF'($urandom) & NF'($urandom);
    else if (full_cnt < full_len && q_fifo[full_fifo].size() == full_idx) begin
      r_full[full_fifo] = 1'b1;
      full_cnt++;
    end
  end

  task automatic clear_fifos();
    for (int f = 0; f < NF; f++) q_fifo[f].delete();
    stall_cnt  = 0;
    full_cnt   = 0;
    n_acc      = 0;
    first_addr = -1;
  endtask

  task automatic run_load(input int exp_cyc, input bit toggle, input string tag);
    int got = 0;
    logic [63:0] w;
    clear_fifos();
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk);
      #2;
      if (toggle && (i == 20 || i == 40)) start = 1'b0;
      if (toggle && (i == 30 || i == 50)) start = 1'b1;
      if (done) begin
        got = i;
        break;
      end
    end
    if (got == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_done_wait: done never asserted, required within 3000 cycles", tag);
      start = 1'b0;
      return;
    end
    if (exp_cyc > 0) chk({tag, "_latency"}, 64'(got), 64'(exp_cyc));
    else chk({tag, "_latency_min"}, 64'(got >= 100), 64'd1);
    chk({tag, "_first_addr"}, 64'(first_addr), 64'(BASE));
    chk({tag, "_reads"}, 64'(n_acc), 64'(NF));
    chk({tag, "_error"}, 64'(error), 64'd0);
    for (int f = 0; f < NF; f++) begin
      w = '0;
      for (int k = 0; k < 8 && k < q_fifo[f].size(); k++) w[8*k +: 8] = q_fifo[f][k];
      chk($sformatf("%s_fifo%0d_count", tag, f), 64'(q_fifo[f].size()), 64'd8);
      chk($sformatf("%s_fifo%0d_bytes", tag, f), w, mem[f]);
    end
    repeat (10) @(posedge clk);
    #2;
    chk({tag, "_done_held"}, {62'd0, done, busy}, 64'd2);
    chk({tag, "_no_reload"}, 64'(n_acc), 64'(NF));
    start = 1'b0;
    @(posedge clk);
    #2;
    chk({tag, "_idle_after"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int nw, got;

    tbl[0] = '{1, 0, 0, 0, 1, 0, 100};
    tbl[1] = '{1, 3, 5, 0, 1, 0, 105};
    tbl[2] = '{1, 0, 0, 2, 3, 4, 104};
    tbl[3] = '{1, 0, 2, 8, 7, 3, 105};
    tbl[4] = '{3, 0, 0, 0, 1, 0, 118};

    for (int r = 0; r < NF; r++)
      mem[r] = 64'h0807060504030201 + 64'(r) * 64'h0101010101010101;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_status", {61'd0, busy, done, error}, 64'd0);
    chk("rst_avm", {31'd0, bus.avm_read, bus.avm_address}, 64'd0);
    chk("rst_fifo", {47'd0, bus.fifo_wr_en, bus.fifo_wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("idle_after_rst", {61'd0, busy, done, bus.avm_read}, 64'd0);

    for (int v = 0; v < 5; v++) begin
      lat       = tbl[v].lat;
      stall_row = tbl[v].stall_row;
      stall_len = tbl[v].stall_len;
      full_fifo = tbl[v].full_fifo;
      full_idx  = tbl[v].full_idx;
      full_len  = tbl[v].full_len;
      run_load(tbl[v].exp_cyc, 1'b0, $sformatf("vec%0d", v));
    end
    lat = 1; stall_len = 0; full_len = 0;

    run_load(100, 1'b1, "start_toggle");

    // Reset while row 5 is being unpacked
    clear_fifos();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 300 && q_fifo[5].size() != 3; i++) begin
      @(posedge clk);
      #2;
    end
    chk("mid_rst_reached_row5", 64'(q_fifo[5].size()), 64'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_status", {61'd0, busy, done, error}, 64'd0);
    chk("async_rst_avm", {31'd0, bus.avm_read, bus.avm_address}, 64'd0);
    chk("async_rst_fifo", {47'd0, bus.fifo_wr_en, bus.fifo_wdata}, 64'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nw = n_wr;
    repeat (10) @(posedge clk);
    #2;
    chk("post_rst_no_writes", 64'(n_wr), 64'(nw));
    chk("post_rst_idle", {62'd0, busy, done}, 64'd0);
    run_load(100, 1'b0, "after_rst");

    // Randomized memory contents, waitstates, latency and backpressure
    rnd_mode = 1'b1;
    for (int n = 0; n < 6; n++) begin
      lat = int'($urandom_range(1, 4));
      for (int r = 0; r < NF; r++) mem[r] = {$urandom, $urandom};
      run_load(0, 1'b0, $sformatf("rand%0d", n));
    end
    rnd_mode = 1'b0;
    lat = 1;

`ifdef MAC_FIFO_LOADER_TIMEOUT_EN
    rdv_en = 1'b0;
    clear_fifos();
    nw  = n_wr;
    got = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #2;
      if (done) begin
        got = i;
        break;
      end
    end
    chk("tmo_latency_window", 64'(got >= 255 && got <= 258), 64'd1);
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_no_writes", 64'(n_wr), 64'(nw));
    start = 1'b0;
    @(posedge clk);
    #2;
    chk("tmo_error_clear", {62'd0, error, done}, 64'd0);
    rdv_en = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "global timeout");
  end

endmodule : tb_mac_fifo_loader
`default_nettype wire
